mac_array_grid: RTL and testbench

Parametrised ROWS×COLS signed INT8 multiply-accumulate array for the DPU compute path. It computes ROWS output-channel partial sums over a stream of COLS-wide activation/weight beats. Accumulation is internal across a group of beats delimited by first/last flags. Results go out through a valid/ready output register. It sits between the weight/activation buffers and the requantisation stage.

---
 rtl/mac_array_grid_pkg.sv | 10 +
 rtl/mac_array_grid_if.sv | 11 +
 rtl/mac_array_grid_row.sv | 50 +++++
 rtl/mac_array_grid.sv | 65 ++++++
 tb/tb_mac_array_grid.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mac_array_grid_pkg.sv
// mac_array_grid_pkg: shared types and sizing helper for the INT8 MAC array
package dpu_mac_pkg;
  typedef logic signed [7:0] act_t;
  typedef logic signed [7:0] wgt_t;
  typedef logic signed [15:0] prod_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} mac_state_e;
  function automatic int sum_w(input int cols);
    return 16 + $clog2(cols);
  endfunction
endpackage

// File: rtl/mac_array_grid_if.sv
// mac_array_grid_if: beat input and result output bundle of the MAC array
interface mac_array_grid_if #(parameter int ROWS = 4, parameter int COLS = 4, parameter int ACC_W = 32);
  logic in_valid, in_ready, in_first, in_last;
  logic [ROWS*COLS*8-1:0] w;
  logic [COLS*8-1:0] a;
  logic out_valid, out_ready;
  logic [ROWS*ACC_W-1:0] out_acc;
  logic [ROWS-1:0] ovf;
  modport master(output in_valid, in_first, in_last, w, a, out_ready, input in_ready, out_valid, out_acc, ovf);
  modport slave(input in_valid, in_first, in_last, w, a, out_ready, output in_ready, out_valid, out_acc, ovf);
endinterface

// File: rtl/mac_array_grid_row.sv
// mac_row: one output channel -- COLS multipliers, product register, adder tree, accumulator (saturating under MAC_ARRAY_SAT_EN)
module mac_row import dpu_mac_pkg::*; #(
  parameter int COLS = 4,
  parameter int ACC_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld,
  input  logic v1,
  input  logic s1,
  input  logic [COLS*8-1:0] w,
  input  logic [COLS*8-1:0] a,
  output logic signed [ACC_W-1:0] acc,
  output logic ovf
);
  localparam int SUM_W = sum_w(COLS);
  prod_t p [COLS];
  logic signed [SUM_W-1:0] rs;
  logic signed [ACC_W-1:0] ext, base, nxt;
  logic signed [ACC_W:0] s;
  logic clip;
  // register the products of each accepted beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int c = 0; c < COLS; c++) p[c] <= '0;
    else if (ld) for (int c = 0; c < COLS; c++) p[c] <= prod_t'(wgt_t'(w[c*8 +: 8])) * prod_t'(act_t'(a[c*8 +: 8]));
  // sum products, sign-extend to the accumulator, add with optional clipping
  always_comb begin
    rs = '0;
    for (int c = 0; c < COLS; c++) rs = rs + SUM_W'(p[c]);
    for (int i = 0; i < ACC_W; i++) ext[i] = rs[i < SUM_W ? i : SUM_W-1];
    base = s1 ? '0 : acc;
    s = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
`ifdef MAC_ARRAY_SAT_EN
    clip = s[ACC_W] != s[ACC_W-1];
    nxt = clip ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
`else
    clip = 1'b0;
    nxt = s[ACC_W-1:0];
`endif
  end
  // accumulate and keep a sticky clip flag that a group start clears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (v1) begin
      acc <= nxt;
      ovf <= (ovf && !s1) || clip;
    end
endmodule

// File: rtl/mac_array_grid.sv
// mac_array_grid: ROWSxCOLS INT8 MAC array with group FSM and held output register; MAC_ARRAY_SAT_EN enables saturation/ovf
module mac_array_grid import dpu_mac_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst_n,
  mac_array_grid_if.slave bus
);
  mac_state_e st, nst;
  logic take, start, v1, s1, l1, l2;
  logic [ROWS*ACC_W-1:0] acc_all;
  logic [ROWS-1:0] ovf_all;
  assign bus.in_ready = st == IDLE || st == ACCUM;
  assign bus.out_valid = st == HOLD;
  assign take = bus.in_valid && bus.in_ready;
  assign start = st == IDLE || bus.in_first;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nst;
  // next state: open/close groups, wait for the last accumulate, then the handshake
  always_comb begin
    nst = st;
    if (take) nst = bus.in_last ? DRAIN : ACCUM;
    else if (st == DRAIN && l2) nst = HOLD;
    else if (st == HOLD && bus.out_ready) nst = IDLE;
  end
  // beat flags travelling alongside the product and accumulate stages
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      v1 <= take;
      s1 <= take && start;
      l1 <= take && bus.in_last;
      l2 <= v1 && l1;
    end
  // output register, loaded only when a group's final accumulate has landed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_acc <= '0;
      bus.ovf <= '0;
    end else if (l2) begin
      bus.out_acc <= acc_all;
      bus.ovf <= ovf_all;
    end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    mac_row #(.COLS(COLS), .ACC_W(ACC_W)) u_row (
      .clk(clk),
      .rst_n(rst_n),
      .ld(take),
      .v1(v1),
      .s1(s1),
      .w(bus.w[r*COLS*8 +: COLS*8]),
      .a(bus.a),
      .acc(acc_all[r*ACC_W +: ACC_W]),
      .ovf(ovf_all[r])
    );
  end
endmodule

// File: tb/tb_mac_array_grid.sv
// tb_mac_array_grid: directed checks of the MAC array (default 4x4x32 and a 1x4x17 saturation instance)
module tb_mac_array_grid;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  logic [127:0] cap;
  always #5 clk = ~clk;
  mac_array_grid_if #(.ROWS(4), .COLS(4), .ACC_W(32)) b0 ();
  mac_array_grid_if #(.ROWS(1), .COLS(4), .ACC_W(17)) b1 ();
  mac_array_grid #(.ROWS(4), .COLS(4), .ACC_W(32)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mac_array_grid #(.ROWS(1), .COLS(4), .ACC_W(17)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] wr(input int k);
    logic [127:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[(r*4+c)*8 +: 8] = 8'(k*(r+1));
    return v;
  endfunction
  task automatic beat(input logic f, input logic l, input logic [127:0] wv, input logic [31:0] av);
    chk("beat_ready", b0.in_ready, 1'b1);
    b0.in_valid = 1'b1;
    b0.in_first = f;
    b0.in_last = l;
    b0.w = wv;
    b0.a = av;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b0.in_first = 1'b0;
    b0.in_last = 1'b0;
  endtask
  task automatic wait_out(input string tag);
    n = 0;
    while (!b0.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 128'(n), 128'd2);
  endtask
  task automatic handshake();
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b0.out_ready = 1'b0;
    chk("hs_valid", b0.out_valid, 1'b0);
    chk("hs_ready", b0.in_ready, 1'b1);
  endtask
  task automatic drain_b2b(input string tag);
    n = 0;
    cap = '0;
    while (!b0.in_ready && n < 20) begin
      if (b0.out_valid) cap = 128'(b0.out_acc);
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 128'(n), 128'd3);
  endtask
  initial begin
    b0.in_valid = 0; b0.in_first = 0; b0.in_last = 0; b0.w = '0; b0.a = '0; b0.out_ready = 0;
    b1.in_valid = 0; b1.in_first = 0; b1.in_last = 0; b1.w = '0; b1.a = '0; b1.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", b0.in_ready, 1'b1);
    chk("rst_valid", b0.out_valid, 1'b0);
    chk("rst_acc", b0.out_acc, '0);
    chk("rst_ovf", b0.ovf, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1, 0, {16{8'h01}}, 32'h04030201);
    beat(0, 0, {16{8'h01}}, 32'h04030201);
    beat(0, 1, {16{8'h01}}, 32'h04030201);
    chk("drain_ready", b0.in_ready, 1'b0);
    wait_out("lat3");
    chk("sum30", b0.out_acc, {4{32'd30}});
    chk("hold_ready", b0.in_ready, 1'b0);
    handshake();
    beat(1, 1, {16{8'h80}}, 32'h80808080);
    wait_out("lat1");
    b0.in_valid = 1'b1; b0.in_first = 1'b1; b0.in_last = 1'b1; b0.w = {16{8'h11}}; b0.a = 32'h22334455;
    for (int i = 0; i < 5; i++) begin
      chk("neg_acc", b0.out_acc, {4{32'd65536}});
      chk("neg_ready", b0.in_ready, 1'b0);
      chk("neg_valid", b0.out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    b0.in_valid = 1'b0; b0.in_first = 1'b0; b0.in_last = 1'b0;
    handshake();
    chk("after_hold_acc", b0.out_acc, {4{32'd65536}});
    beat(1, 0, {16{8'h02}}, 32'h01010101);
    beat(0, 0, {16{8'h02}}, 32'h02020202);
    beat(1, 0, {16{8'h02}}, 32'h03030303);
    beat(0, 1, {16{8'h02}}, 32'h01010101);
    wait_out("lat_rs");
    chk("restart", b0.out_acc, {4{32'd32}});
    handshake();
    b0.out_ready = 1'b1;
    beat(1, 0, wr(1), 32'h01010101);
    beat(0, 1, wr(1), 32'h03030303);
    drain_b2b("b2b_busy_a");
    chk("b2b_a", cap, 128'({32'd64, 32'd48, 32'd32, 32'd16}));
    beat(1, 1, wr(1), 32'hFFFFFFFF);
    drain_b2b("b2b_busy_b");
    chk("b2b_b", cap, 128'({32'hFFFFFFF0, 32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC}));
    b0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b1.in_valid = 1'b1; b1.in_first = i == 0; b1.in_last = i == 4;
      b1.w = 32'h7F7F7F7F; b1.a = 32'h7F7F7F7F;
      @(posedge clk);
      #1;
    end
    b1.in_valid = 1'b0; b1.in_first = 1'b0; b1.in_last = 1'b0;
    n = 0;
    while (!b1.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sat_lat", 128'(n), 128'd2);
`ifdef MAC_ARRAY_SAT_EN
    chk("sat_acc", b1.out_acc, 17'h0FFFF);
    chk("sat_ovf", b1.ovf, 1'b1);
`else
    chk("wrap_acc", b1.out_acc, 17'd60436);
    chk("wrap_ovf", b1.ovf, 1'b0);
`endif
    b1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.out_ready = 1'b0;
    beat(1, 0, {16{8'h01}}, 32'h05050505);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", b0.in_ready, 1'b1);
    chk("rst_mid_valid", b0.out_valid, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(0, 1, {16{8'h01}}, 32'h01010101);
    wait_out("lat_post_rst");
    chk("no_stale", b0.out_acc, {4{32'd4}});
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", b0.out_valid, 1'b0);
    chk("rst_hold_ready", b0.in_ready, 1'b1);
    chk("rst_hold_acc", b0.out_acc, '0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(0, 0, {16{8'h01}}, 32'h02020202);
    beat(0, 1, {16{8'h01}}, 32'h01010101);
    wait_out("lat_post_rst2");
    chk("no_stale2", b0.out_acc, {4{32'd12}});
    handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
